// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared types and constants for the Z80 bus responder.
//   cyc_e    - latched bus-cycle type
//   state_t  - responder FSM state encoding (ST_IDLE/ST_WAIT/ST_ACCESS/ST_HOLD)
//   OPEN_BUS - value returned for unmapped/out-of-range reads
package z80_bus_pkg;

    typedef enum logic [2:0] {
        CYC_MEM_RD,
        CYC_MEM_WR,
        CYC_IO_RD,
        CYC_IO_WR,
        CYC_INTACK
    } cyc_e;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    localparam logic [7:0] OPEN_BUS = 8'hFF;

    function automatic logic is_mem(input cyc_e c);
        return (c == CYC_MEM_RD) || (c == CYC_MEM_WR);
    endfunction

endpackage

// File: rtl/z80_sync_ram.sv
// z80_sync_ram: single-port RAM with registered read, 8-bit wide.
//   clk   - clock
//   we    - write enable (writes wdata to addr)
//   re    - read enable (rdata <= mem[addr] on the next edge)
//   addr  - word address, MEM_AW bits
//   wdata - write data
//   rdata - registered read data (not reset, so it maps to block RAM)
module z80_sync_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [MEM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: target-side agent on the Z80 external bus. Serves memory
// cycles from an internal RAM and I/O cycles from a small register bank,
// inserting programmable wait states.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   address_bus         - CPU address (sampled only at cycle start)
//   data_in / data_out  - CPU write data / read data, data_oe = drive enable
//   mreq,iorq,rd,wr,m1,rfsh - active-low CPU strobes
//   wait_n              - active-low wait request
//   io_regs             - flat I/O register contents, port 0 in [7:0]
//   bus_err             - one-cycle pulse on an illegal strobe combination
//   int_vec, intack     - interrupt acknowledge vector / pulse
// Optional feature: define Z80_INTACK_EN to answer m1+iorq interrupt
// acknowledge cycles with int_vec; otherwise they are ignored, intack = 0.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int         MEM_AW   = 12,
    parameter int         MEM_WAIT = 1,
    parameter int         IO_WAIT  = 1,
    parameter logic [7:0] IO_BASE  = 8'h10,
    parameter int         IO_PORTS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           address_bus,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    input  logic                  mreq,
    input  logic                  iorq,
    input  logic                  rd,
    input  logic                  wr,
    input  logic                  m1,
    input  logic                  rfsh,
    output logic                  wait_n,
    output logic [8*IO_PORTS-1:0] io_regs,
    output logic                  bus_err,
    input  logic [7:0]            int_vec,
    output logic                  intack
);

    state_t                     state;
    cyc_e                       cyc_q;
    logic [15:0]                addr_q;
    logic [2:0]                 cnt;
    logic [7:0]                 data_q;
    logic                       use_ram;
    logic                       illegal_q;
    logic [IO_PORTS-1:0][7:0]   io_q;
    logic [7:0]                 ram_q;

    // ---- cycle-start decode (only acted on in IDLE) ----
    logic start, illegal;
    cyc_e start_cyc;
    logic [2:0] start_wait;

    always_comb begin
        start     = 1'b0;
        illegal   = 1'b0;
        start_cyc = CYC_MEM_RD;
        if (!m1 && !iorq) begin
            // interrupt acknowledge; silently ignored when the feature is off
`ifdef Z80_INTACK_EN
            start     = 1'b1;
            start_cyc = CYC_INTACK;
`endif
        end else if (!mreq && !rfsh) begin
            // refresh: no response
        end else if (!mreq && !iorq) begin
            illegal = 1'b1;
        end else if (!mreq || !iorq) begin
            if (!rd && !wr) begin
                illegal = 1'b1;
            end else if (!rd || !wr) begin
                // m1 fetch with mreq+rd falls through as a plain memory read
                start = 1'b1;
                if (!mreq) start_cyc = !rd ? CYC_MEM_RD : CYC_MEM_WR;
                else       start_cyc = !rd ? CYC_IO_RD  : CYC_IO_WR;
            end
        end
        start_wait = is_mem(start_cyc) ? 3'(MEM_WAIT) : 3'(IO_WAIT);
    end

    // strobe release ends a cycle (abort from WAIT, completion from HOLD)
    logic rel;
    assign rel = (cyc_q == CYC_INTACK) ? (iorq && m1) : (rd && wr);

    // ---- address decode on the latched address ----
    logic       mem_in_range;
    logic [7:0] io_off;
    logic       io_hit;
    logic [7:0] io_rd_data;

    assign mem_in_range = (addr_q >> MEM_AW) == 16'd0;
    assign io_off       = addr_q[7:0] - IO_BASE;
    assign io_hit       = (addr_q[7:0] >= IO_BASE) && (io_off < 8'(IO_PORTS));

    always_comb begin
        io_rd_data = OPEN_BUS;
        for (int i = 0; i < IO_PORTS; i++)
            if (io_hit && io_off == 8'(i)) io_rd_data = io_q[i];
    end

    // ---- RAM ----
    logic ram_we, ram_re;
    assign ram_we = (state == ST_ACCESS) && (cyc_q == CYC_MEM_WR) && mem_in_range;
    assign ram_re = (state == ST_ACCESS) && (cyc_q == CYC_MEM_RD);

    z80_sync_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q[MEM_AW-1:0]),
        .wdata (data_in),
        .rdata (ram_q)
    );

`ifdef Z80_INTACK_EN
    logic intack_q;
    assign intack = intack_q;
`else
    logic unused_int_vec;
    assign unused_int_vec = ^int_vec;
    assign intack = 1'b0;
`endif

    // ---- FSM ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cyc_q     <= CYC_MEM_RD;
            addr_q    <= '0;
            cnt       <= '0;
            data_q    <= '0;
            use_ram   <= 1'b0;
            data_oe   <= 1'b0;
            bus_err   <= 1'b0;
            illegal_q <= 1'b0;
            io_q      <= '0;
`ifdef Z80_INTACK_EN
            intack_q  <= 1'b0;
`endif
        end else begin
            bus_err   <= 1'b0;
            illegal_q <= illegal && (state == ST_IDLE);
`ifdef Z80_INTACK_EN
            intack_q  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // edge-detect so a held illegal combination pulses once
                    if (illegal && !illegal_q) bus_err <= 1'b1;
                    if (start) begin
                        addr_q <= address_bus;
                        cyc_q  <= start_cyc;
                        cnt    <= start_wait;
                        state  <= (start_wait != 3'd0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (rel)              state <= ST_IDLE;
                    else if (cnt <= 3'd1) state <= ST_ACCESS;
                    else                  cnt   <= cnt - 3'd1;
                end
                ST_ACCESS: begin
                    state <= ST_HOLD;
                    case (cyc_q)
                        CYC_MEM_RD: begin
                            // RAM data arrives on ram_q at the same edge
                            data_oe <= 1'b1;
                            use_ram <= mem_in_range;
                            data_q  <= OPEN_BUS;
                        end
                        CYC_IO_RD: begin
                            data_oe <= 1'b1;
                            use_ram <= 1'b0;
                            data_q  <= io_rd_data;
                        end
                        CYC_IO_WR: begin
                            for (int i = 0; i < IO_PORTS; i++)
                                if (io_hit && io_off == 8'(i)) io_q[i] <= data_in;
                        end
`ifdef Z80_INTACK_EN
                        CYC_INTACK: begin
                            data_oe  <= 1'b1;
                            use_ram  <= 1'b0;
                            data_q   <= int_vec;
                            intack_q <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                default: begin // ST_HOLD
                    if (rel) begin
                        state   <= ST_IDLE;
                        data_oe <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wait_n   = (state != ST_WAIT);
    assign data_out = use_ram ? ram_q : data_q;
    assign io_regs  = io_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
module tb_z80_bus_responder;

    // strobe patterns, order {mreq, iorq, rd, wr, m1, rfsh}, active low
    localparam logic [5:0] S_IDLE  = 6'b111111;
    localparam logic [5:0] S_MRD   = 6'b010111;
    localparam logic [5:0] S_MWR   = 6'b011011;
    localparam logic [5:0] S_FETCH = 6'b010101;
    localparam logic [5:0] S_IORD  = 6'b100111;
    localparam logic [5:0] S_IOWR  = 6'b101011;
    localparam logic [5:0] S_INTA  = 6'b101101;
    localparam logic [5:0] S_RFSH  = 6'b011110;
    localparam logic [5:0] S_RDWR  = 6'b010011;
    localparam logic [5:0] S_MEMIO = 6'b000111;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address_bus;
    logic [7:0]  data_in, data_out, int_vec;
    logic        data_oe, mreq, iorq, rd, wr, m1, rfsh;
    logic        wait_n, bus_err, intack;
    logic [31:0] io_regs;

    int checks = 0;
    int errors = 0;

    // results of the last bus_cycle
    int         r_wait, r_lat, r_intack, r_err;
    logic [7:0] r_data;
    logic       r_oe_after;

    always #5 clk = ~clk;

    z80_bus_responder dut (
        .clk(clk), .reset(reset), .address_bus(address_bus),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1), .rfsh(rfsh),
        .wait_n(wait_n), .io_regs(io_regs), .bus_err(bus_err),
        .int_vec(int_vec), .intack(intack)
    );

    task automatic idle_bus();
        {mreq, iorq, rd, wr, m1, rfsh} = S_IDLE;
    endtask

    // Holds the strobes for 6 cycles, measuring wait cycles, the cycle on
    // which data_oe first rises (and data_out then), intack/bus_err pulses.
    // The address is scrambled after the first edge to prove it is latched.
    task automatic bus_cycle(input logic [5:0] strb, input logic [15:0] a,
                             input logic [7:0] d);
        @(negedge clk);
        {mreq, iorq, rd, wr, m1, rfsh} = strb;
        address_bus = a;
        data_in = d;
        r_wait = 0; r_lat = 0; r_intack = 0; r_err = 0; r_data = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (!wait_n) r_wait++;
            if (intack) r_intack++;
            if (bus_err) r_err++;
            if (data_oe && r_lat == 0) begin r_lat = i; r_data = data_out; end
            address_bus = ~a;
        end
        idle_bus();
        @(negedge clk);
        r_oe_after = data_oe;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_bus();
        address_bus = 16'h0000; data_in = 8'h00; int_vec = 8'hFF;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe: got %b want 0", data_oe); end
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n: got %b want 1", wait_n); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
        checks++; if (intack !== 1'b0) begin errors++; $display("FAIL rst_intack: got %b want 0", intack); end
        checks++; if (io_regs !== 32'h0) begin errors++; $display("FAIL rst_io_regs: got %h want 0", io_regs); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mem_rw();
        bus_cycle(S_MWR, 16'h0123, 8'hA5);
        checks++; if (r_wait !== 1) begin errors++; $display("FAIL mwr_wait: got %0d want 1", r_wait); end
        checks++; if (r_lat !== 0) begin errors++; $display("FAIL mwr_no_oe: got lat %0d want 0", r_lat); end
        bus_cycle(S_MRD, 16'h0123, 8'h00);
        checks++; if (r_wait !== 1) begin errors++; $display("FAIL mrd_wait: got %0d want 1", r_wait); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL mrd_latency: got %0d want 3", r_lat); end
        checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL mrd_data: got %h want a5", r_data); end
        checks++; if (r_oe_after !== 1'b0) begin errors++; $display("FAIL mrd_oe_release: got %b want 0", r_oe_after); end
        // opcode fetch is a read
        bus_cycle(S_FETCH, 16'h0123, 8'h00);
        checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL fetch_data: got %h want a5", r_data); end
    endtask

    task automatic test_io();
        bus_cycle(S_IOWR, 16'h0012, 8'h3C);
        checks++; if (io_regs[23:16] !== 8'h3C) begin errors++; $display("FAIL io_wr_reg: got %h want 3c", io_regs[23:16]); end
        checks++; if (io_regs[7:0] !== 8'h00) begin errors++; $display("FAIL io_wr_other: got %h want 00", io_regs[7:0]); end
        bus_cycle(S_IORD, 16'h0012, 8'h00);
        checks++; if (r_data !== 8'h3C) begin errors++; $display("FAIL io_rd_data: got %h want 3c", r_data); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL io_rd_latency: got %0d want 3", r_lat); end
        bus_cycle(S_IOWR, 16'h0040, 8'h77);
        checks++; if (io_regs !== 32'h003C_0000) begin errors++; $display("FAIL io_unmapped_wr: got %h want 003c0000", io_regs); end
        bus_cycle(S_IORD, 16'h0040, 8'h00);
        checks++; if (r_data !== 8'hFF) begin errors++; $display("FAIL io_unmapped_rd: got %h want ff", r_data); end
        bus_cycle(S_IORD, 16'h0013, 8'h00);
        checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL io_last_port: got %h want 00", r_data); end
    endtask

    task automatic test_out_of_range();
        bus_cycle(S_MWR, 16'h0000, 8'h42);
        bus_cycle(S_MRD, 16'hF000, 8'h00);
        checks++; if (r_data !== 8'hFF) begin errors++; $display("FAIL oor_rd: got %h want ff", r_data); end
        bus_cycle(S_MWR, 16'hF000, 8'h5A);
        bus_cycle(S_MRD, 16'h0000, 8'h00);
        checks++; if (r_data !== 8'h42) begin errors++; $display("FAIL oor_wr_dropped: got %h want 42", r_data); end
        bus_cycle(S_MRD, 16'h0FFF, 8'h00);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL top_addr_latency: got %0d want 3", r_lat); end
    endtask

    task automatic test_illegal();
        bus_cycle(S_RDWR, 16'h0123, 8'h00);
        checks++; if (r_err !== 1) begin errors++; $display("FAIL rdwr_bus_err: got %0d pulses want 1", r_err); end
        checks++; if (r_wait !== 0) begin errors++; $display("FAIL rdwr_wait: got %0d want 0", r_wait); end
        bus_cycle(S_MEMIO, 16'h0012, 8'h00);
        checks++; if (r_err !== 1) begin errors++; $display("FAIL memio_bus_err: got %0d pulses want 1", r_err); end
        checks++; if (r_lat !== 0) begin errors++; $display("FAIL memio_no_oe: got lat %0d want 0", r_lat); end
        bus_cycle(S_RFSH, 16'h0123, 8'h00);
        checks++; if (r_err + r_wait + r_lat !== 0) begin errors++; $display("FAIL refresh_quiet: got err %0d wait %0d lat %0d want 0", r_err, r_wait, r_lat); end
    endtask

    task automatic test_early_release();
        bus_cycle(S_MWR, 16'h0020, 8'h77);
        @(negedge clk);
        {mreq, iorq, rd, wr, m1, rfsh} = S_MWR;
        address_bus = 16'h0020; data_in = 8'h55;
        @(negedge clk);
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got wait_n %b want 0", wait_n); end
        idle_bus();
        @(negedge clk);
        bus_cycle(S_MRD, 16'h0020, 8'h00);
        checks++; if (r_data !== 8'h77) begin errors++; $display("FAIL abort_no_write: got %h want 77", r_data); end
        checks++; if (r_err !== 0) begin errors++; $display("FAIL abort_no_err: got %0d want 0", r_err); end
    endtask

    task automatic test_reset_midcycle();
        bus_cycle(S_MWR, 16'h0010, 8'h11);
        @(negedge clk);
        {mreq, iorq, rd, wr, m1, rfsh} = S_MWR;
        address_bus = 16'h0010; data_in = 8'h99;
        @(negedge clk);
        checks++; if (wait_n !== 1'b0) begin errors++; $display("FAIL midrst_in_wait: got wait_n %b want 0", wait_n); end
        reset = 1'b0;
        #1;
        checks++; if (wait_n !== 1'b1) begin errors++; $display("FAIL midrst_wait_n: got %b want 1", wait_n); end
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL midrst_data_oe: got %b want 0", data_oe); end
        checks++; if (io_regs !== 32'h0) begin errors++; $display("FAIL midrst_io_regs: got %h want 0", io_regs); end
        idle_bus();
        @(negedge clk);
        reset = 1'b1;
        bus_cycle(S_MRD, 16'h0010, 8'h00);
        checks++; if (r_data !== 8'h11) begin errors++; $display("FAIL midrst_ram_kept: got %h want 11", r_data); end
    endtask

    task automatic test_back_to_back();
        bus_cycle(S_MWR, 16'h0456, 8'hC3);
        bus_cycle(S_MWR, 16'h0457, 8'h3C);
        bus_cycle(S_MRD, 16'h0457, 8'h00);
        checks++; if (r_data !== 8'h3C) begin errors++; $display("FAIL b2b_rd1: got %h want 3c", r_data); end
        bus_cycle(S_MRD, 16'h0456, 8'h00);
        checks++; if (r_data !== 8'hC3) begin errors++; $display("FAIL b2b_rd0: got %h want c3", r_data); end
    endtask

    task automatic test_intack();
        int_vec = 8'hFF;
        bus_cycle(S_INTA, 16'h0038, 8'h00);
`ifdef Z80_INTACK_EN
        checks++; if (r_data !== 8'hFF) begin errors++; $display("FAIL inta_data: got %h want ff", r_data); end
        checks++; if (r_intack !== 1) begin errors++; $display("FAIL inta_pulse: got %0d want 1", r_intack); end
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL inta_latency: got %0d want 3", r_lat); end
        int_vec = 8'hC7;
        bus_cycle(S_INTA, 16'h0000, 8'h00);
        checks++; if (r_data !== 8'hC7) begin errors++; $display("FAIL inta_vec2: got %h want c7", r_data); end
`else
        checks++; if (r_lat !== 0) begin errors++; $display("FAIL inta_off_oe: got lat %0d want 0", r_lat); end
        checks++; if (r_err !== 0) begin errors++; $display("FAIL inta_off_err: got %0d want 0", r_err); end
        checks++; if (r_intack !== 0) begin errors++; $display("FAIL inta_off_pulse: got %0d want 0", r_intack); end
`endif
    endtask

    initial begin
        test_reset();
        test_mem_rw();
        test_io();
        test_out_of_range();
        test_illegal();
        test_early_release();
        test_reset_midcycle();
        test_back_to_back();
        test_intack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
